// File: rtl/gradient_ctx_gen_if.sv
// Pixel-in / context-out bundle for gradient_ctx_gen.
// The run_mode signal exists only when GRAD_RUN_EN is defined.
interface gradient_ctx_gen_if;
  logic              en;
  logic              sof;
  logic [7:0]        pix;
  logic signed [8:0] D1;
  logic signed [8:0] D2;
  logic signed [8:0] D3;
  logic [7:0]        Ra;
  logic [7:0]        Rb;
  logic [7:0]        Rc;
  logic [7:0]        Rx;
  logic              eol;
  logic              en_out;
`ifdef GRAD_RUN_EN
  logic              run_mode;
`endif

  modport master (
    output en,
    output sof,
    output pix,
`ifdef GRAD_RUN_EN
    input  run_mode,
`endif
    input  D1,
    input  D2,
    input  D3,
    input  Ra,
    input  Rb,
    input  Rc,
    input  Rx,
    input  eol,
    input  en_out
  );

  modport slave (
    input  en,
    input  sof,
    input  pix,
`ifdef GRAD_RUN_EN
    output run_mode,
`endif
    output D1,
    output D2,
    output D3,
    output Ra,
    output Rb,
    output Rc,
    output Rx,
    output eol,
    output en_out
  );
endinterface

// File: rtl/gradient_ctx_gen.sv
// LOCO-I causal neighbourhood (a,b,c,d) builder and local gradient stage, one register deep.
// Optional feature macro: GRAD_RUN_EN adds the registered run_mode (flat context) output.
module gradient_ctx_gen #(
  parameter int IMG_WIDTH = 256,
  parameter int COL_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  gradient_ctx_gen_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

  // Context state
  logic [COL_W-1:0] col_q, col_d;
  logic             first_row_q, first_row_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       c_q, c_d;
  logic [7:0]       b_col0_q, b_col0_d;

  // Previous line; contents are don't-care after reset
  logic [7:0]       lb_q [IMG_WIDTH];

  // Registered outputs
  logic signed [8:0] d1_q, d1_d;
  logic signed [8:0] d2_q, d2_d;
  logic signed [8:0] d3_q, d3_d;
  logic [7:0]        ra_q, ra_d;
  logic [7:0]        rb_q, rb_d;
  logic [7:0]        rc_q, rc_d;
  logic [7:0]        rx_q, rx_d;
  logic              eol_q, eol_d;
  logic              en_out_q, en_out_d;
`ifdef GRAD_RUN_EN
  logic              run_mode_q, run_mode_d;
`endif

  // Neighbourhood signals for the pixel currently presented
  logic [COL_W-1:0]  eff_col_s;
  logic              eff_first_s;
  logic              col_last_s;
  logic [COL_W-1:0]  d_idx_s;
  logic [7:0]        lb_b_s;
  logic [7:0]        lb_d_s;
  logic [7:0]        a_s, b_s, c_s, d_s;
  logic signed [8:0] g1_s, g2_s, g3_s;

  function automatic logic signed [8:0] diff9(input logic [7:0] x, input logic [7:0] y);
    return $signed({1'b0, x}) - $signed({1'b0, y});
  endfunction

  // Effective position (sof restarts the frame) and neighbourhood selection
  always_comb begin
    eff_col_s   = bus.sof ? COL_ZERO : col_q;
    eff_first_s = bus.sof | first_row_q;
    col_last_s  = (eff_col_s == LAST_COL);
    // At the last column d re-reads lb[col], which makes d equal b
    d_idx_s     = col_last_s ? eff_col_s : (eff_col_s + COL_W'(1));
    lb_b_s      = lb_q[eff_col_s];
    lb_d_s      = lb_q[d_idx_s];

    if (eff_first_s) begin
      b_s = 8'd0;
      c_s = 8'd0;
      d_s = 8'd0;
      a_s = (eff_col_s == COL_ZERO) ? 8'd0 : a_q;
    end else if (eff_col_s == COL_ZERO) begin
      b_s = lb_b_s;
      a_s = lb_b_s;
      c_s = b_col0_q;
      d_s = lb_d_s;
    end else begin
      b_s = lb_b_s;
      a_s = a_q;
      c_s = c_q;
      d_s = lb_d_s;
    end

    g1_s = diff9(d_s, b_s);
    g2_s = diff9(b_s, c_s);
    g3_s = diff9(c_s, a_s);
  end

  // Next state for counters and context registers; everything holds while en is low
  always_comb begin
    col_d       = col_q;
    first_row_d = first_row_q;
    a_d         = a_q;
    c_d         = c_q;
    b_col0_d    = b_col0_q;
    if (bus.en) begin
      col_d       = col_last_s ? COL_ZERO : (eff_col_s + COL_W'(1));
      first_row_d = col_last_s ? 1'b0 : eff_first_s;
      a_d         = bus.pix;
      c_d         = b_s;
      b_col0_d    = (eff_col_s == COL_ZERO) ? b_s : b_col0_q;
    end else begin
      col_d       = col_q;
      first_row_d = first_row_q;
    end
  end

  // Output next values, zeroed whenever no pixel is accepted
  always_comb begin
    d1_d     = 9'sd0;
    d2_d     = 9'sd0;
    d3_d     = 9'sd0;
    ra_d     = 8'd0;
    rb_d     = 8'd0;
    rc_d     = 8'd0;
    rx_d     = 8'd0;
    eol_d    = 1'b0;
    en_out_d = 1'b0;
`ifdef GRAD_RUN_EN
    run_mode_d = 1'b0;
`endif
    if (bus.en) begin
      d1_d     = g1_s;
      d2_d     = g2_s;
      d3_d     = g3_s;
      ra_d     = a_s;
      rb_d     = b_s;
      rc_d     = c_s;
      rx_d     = bus.pix;
      eol_d    = col_last_s;
      en_out_d = 1'b1;
`ifdef GRAD_RUN_EN
      run_mode_d = (g1_s == 9'sd0) && (g2_s == 9'sd0) && (g3_s == 9'sd0);
`endif
    end else begin
      en_out_d = 1'b0;
    end
  end

  // Context and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= COL_ZERO;
      first_row_q <= 1'b1;
      a_q         <= 8'd0;
      c_q         <= 8'd0;
      b_col0_q    <= 8'd0;
      d1_q        <= 9'sd0;
      d2_q        <= 9'sd0;
      d3_q        <= 9'sd0;
      ra_q        <= 8'd0;
      rb_q        <= 8'd0;
      rc_q        <= 8'd0;
      rx_q        <= 8'd0;
      eol_q       <= 1'b0;
      en_out_q    <= 1'b0;
`ifdef GRAD_RUN_EN
      run_mode_q  <= 1'b0;
`endif
    end else begin
      col_q       <= col_d;
      first_row_q <= first_row_d;
      a_q         <= a_d;
      c_q         <= c_d;
      b_col0_q    <= b_col0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      rx_q        <= rx_d;
      eol_q       <= eol_d;
      en_out_q    <= en_out_d;
`ifdef GRAD_RUN_EN
      run_mode_q  <= run_mode_d;
`endif
    end
  end

  // Line buffer write; b and d were read from the old contents this same cycle
  always_ff @(posedge clk) begin
    if (bus.en) begin
      lb_q[eff_col_s] <= bus.pix;
    end
  end

  assign bus.D1     = d1_q;
  assign bus.D2     = d2_q;
  assign bus.D3     = d3_q;
  assign bus.Ra     = ra_q;
  assign bus.Rb     = rb_q;
  assign bus.Rc     = rc_q;
  assign bus.Rx     = rx_q;
  assign bus.eol    = eol_q;
  assign bus.en_out = en_out_q;
`ifdef GRAD_RUN_EN
  assign bus.run_mode = run_mode_q;
`endif

endmodule

// File: tb/tb_gradient_ctx_gen.sv
// Directed bench for gradient_ctx_gen with a 4-pixel line; expected values computed by hand.
module tb_gradient_ctx_gen;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gradient_ctx_gen_if bus ();

  gradient_ctx_gen #(.IMG_WIDTH(4), .COL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input beat, then settle just after the capturing edge
  task automatic px(input logic e, input logic s, input logic [7:0] p);
    @(negedge clk);
    bus.en  = e;
    bus.sof = s;
    bus.pix = p;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [60:0] obs();
    return {bus.D1, bus.D2, bus.D3, bus.Ra, bus.Rb, bus.Rc, bus.Rx, bus.eol, bus.en_out};
  endfunction

  function automatic logic [60:0] pk(input int d1, input int d2, input int d3,
                                     input int ra, input int rb, input int rc, input int rx,
                                     input bit e, input bit v);
    return {9'(d1), 9'(d2), 9'(d3), 8'(ra), 8'(rb), 8'(rc), 8'(rx), e, v};
  endfunction

  task automatic test_reset();
    logic [60:0] o;
    for (int i = 0; i < 3; i++) begin
      px(1'b1, i[0], 8'(77 + i));
      o = obs();
      checks++;
      if (o !== 61'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, o, 61'd0);
      end
`ifdef GRAD_RUN_EN
      checks++;
      if (bus.run_mode !== 1'b0) begin
        errors++;
        $display("FAIL reset_run_mode: got %b expected 0", bus.run_mode);
      end
`endif
    end
    @(negedge clk);
    bus.en = 1'b0;
    reset  = 1'b1;
    px(1'b1, 1'b0, 8'd50);
    o = obs();
    checks++;
    if (o !== pk(0, 0, 0, 0, 0, 0, 50, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_first_px: got %h expected %h", o, pk(0, 0, 0, 0, 0, 0, 50, 1'b0, 1'b1));
    end
  endtask

  task automatic test_first_row();
    int pv [4] = '{10, 20, 30, 40};
    int ra [4] = '{0, 10, 20, 30};
    logic [60:0] o, e;
    for (int i = 0; i < 4; i++) begin
      px(1'b1, (i == 0), 8'(pv[i]));
      o = obs();
      e = pk(0, 0, -ra[i], ra[i], 0, 0, pv[i], (i == 3), 1'b1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL first_row[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_second_row();
    int pv [4] = '{15, 25, 35, 45};
    int d1 [4] = '{10, 10, 10, 0};
    int d2 [4] = '{10, 10, 10, 10};
    int d3 [4] = '{-10, -5, -5, -5};
    int ra [4] = '{10, 15, 25, 35};
    int rb [4] = '{10, 20, 30, 40};
    int rc [4] = '{0, 10, 20, 30};
    logic [60:0] o, e;
    for (int i = 0; i < 4; i++) begin
      px(1'b1, 1'b0, 8'(pv[i]));
      o = obs();
      e = pk(d1[i], d2[i], d3[i], ra[i], rb[i], rc[i], pv[i], (i == 3), 1'b1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL second_row[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_en_gaps();
    bit en_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int pv   [4] = '{5, 6, 7, 8};
    int d1   [4] = '{10, 10, 10, 0};
    int d2   [4] = '{5, 10, 10, 10};
    int d3   [4] = '{-5, 10, 19, 28};
    int ra   [4] = '{15, 5, 6, 7};
    int rb   [4] = '{15, 25, 35, 45};
    int rc   [4] = '{10, 15, 25, 35};
    int k = 0;
    logic [60:0] o, e;
    for (int i = 0; i < 7; i++) begin
      if (en_v[i]) begin
        px(1'b1, 1'b0, 8'(pv[k]));
        e = pk(d1[k], d2[k], d3[k], ra[k], rb[k], rc[k], pv[k], (k == 3), 1'b1);
        k++;
      end else begin
        px(1'b0, 1'b0, 8'd99);
        e = 61'd0;
      end
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_gaps[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_extremes();
    int pv [8] = '{255, 255, 0, 255, 0, 255, 0, 0};
    int d1 [8] = '{0, 0, 0, 0, 0, -255, 255, 0};
    int d2 [8] = '{0, 0, 0, 0, 255, 0, -255, 255};
    int d3 [8] = '{0, -255, -255, 0, -255, 255, 0, 0};
    int ra [8] = '{0, 255, 255, 0, 255, 0, 255, 0};
    int rb [8] = '{0, 0, 0, 0, 255, 255, 0, 255};
    int rc [8] = '{0, 0, 0, 0, 0, 255, 255, 0};
    logic [60:0] o, e;
    for (int i = 0; i < 8; i++) begin
      px(1'b1, (i == 0), 8'(pv[i]));
      o = obs();
      e = pk(d1[i], d2[i], d3[i], ra[i], rb[i], rc[i], pv[i], (i % 4 == 3), 1'b1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL extremes[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_sof_midline();
    logic [60:0] o;
    logic [60:0] e [5];
    e[0] = pk(0, 0, 0, 0, 0, 0, 3, 1'b0, 1'b1);
    e[1] = pk(0, 0, -3, 3, 0, 0, 4, 1'b0, 1'b1);
    e[2] = pk(0, 0, -4, 4, 0, 0, 5, 1'b0, 1'b1);
    e[3] = pk(0, 0, -5, 5, 0, 0, 6, 1'b1, 1'b1);
    e[4] = pk(1, 3, -3, 3, 3, 0, 7, 1'b0, 1'b1);
    px(1'b1, 1'b0, 8'd1);
    px(1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      px(1'b1, (i == 0), 8'(3 + i));
      o = obs();
      checks++;
      if (o !== e[i]) begin
        errors++;
        $display("FAIL sof_midline[%0d]: got %h expected %h", i, o, e[i]);
      end
    end
  endtask

`ifdef GRAD_RUN_EN
  task automatic test_run_mode();
    logic exp_rm;
    for (int i = 0; i < 12; i++) begin
      px(1'b1, (i == 0), 8'd128);
      // Row 0: only col 0 is flat; row 1 col 0 still sees c=0; flat from then on
      exp_rm = (i == 0) || (i >= 5);
      checks++;
      if (bus.run_mode !== exp_rm) begin
        errors++;
        $display("FAIL run_mode[%0d]: got %b expected %b", i, bus.run_mode, exp_rm);
      end
    end
    px(1'b0, 1'b0, 8'd128);
    checks++;
    if (bus.run_mode !== 1'b0) begin
      errors++;
      $display("FAIL run_mode_gap: got %b expected 0", bus.run_mode);
    end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    bus.en  = 1'b0;
    bus.sof = 1'b0;
    bus.pix = 8'd0;
    test_reset();
    test_first_row();
    test_second_row();
    test_en_gaps();
    test_extremes();
    test_sof_midline();
`ifdef GRAD_RUN_EN
    test_run_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
